// File: rtl/uart_tx_word_queue_if.sv
// Bundle of the word-queue signals between the execution stage, the queue and
// the UART byte sender. The queue uses the slave view; the surrounding logic
// (pipeline write port plus byte sender) uses the master view.
interface uart_tx_word_queue_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic [31:0]         wr_data;
  logic                wr_en;
  logic                full;
  logic                empty;
  logic [DEPTH_LOG2:0] count;
  logic                overflow;
  logic                tx_ready;
  logic [7:0]          tx_data;
  logic                tx_start;
  logic                busy;

  modport master (
    output wr_data, wr_en, tx_ready,
    input  full, empty, count, overflow, tx_data, tx_start, busy
  );

  modport slave (
    input  wr_data, wr_en, tx_ready,
    output full, empty, count, overflow, tx_data, tx_start, busy
  );
endinterface

// File: rtl/uart_tx_word_queue.sv
// Word FIFO feeding the UART byte sender. Each queued 32-bit word is sent as
// four bytes, MSB first, using a tx_start pulse / tx_ready handshake.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no word in flight; pops the head word when the FIFO is non-empty
// SEND  | waiting for tx_ready, then pulses tx_start with the top byte
// ACK   | waiting for tx_ready to fall, then shifts to the next byte
module uart_tx_word_queue #(
  parameter int DEPTH_LOG2 = 4
) (
  input logic              CLK,
  input logic              reset,
  uart_tx_word_queue_if.slave bus
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] COUNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_ptr, wr_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  overflow;
  logic                  full, empty;
  logic                  push, pop;

  logic [31:0] shreg, shreg_next;
  logic [1:0]  byte_cnt, byte_cnt_next;
  logic        tx_start, tx_start_next;
  logic [7:0]  tx_data, tx_data_next;

  assign full  = (count == COUNT_FULL);
  assign empty = (count == '0);

  // A write while full is still accepted when the FSM frees a slot this cycle.
  assign push = bus.wr_en && (!full || pop);

  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.count    = count;
  assign bus.overflow = overflow;
  assign bus.tx_data  = tx_data;
  assign bus.tx_start = tx_start;
  assign bus.busy     = (state != IDLE);

  // Storage array: deliberately not reset; only entries below count are read.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= bus.wr_data;
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge CLK) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (bus.wr_en && full && !pop) overflow <= 1'b1;
    end
  end

  // FSM and byte-serializer registers.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state    <= IDLE;
      shreg    <= '0;
      byte_cnt <= '0;
      tx_start <= 1'b0;
      tx_data  <= '0;
    end else begin
      state    <= state_next;
      shreg    <= shreg_next;
      byte_cnt <= byte_cnt_next;
      tx_start <= tx_start_next;
      tx_data  <= tx_data_next;
    end
  end

  // Next-state and serializer decode; tx_start is a single-cycle pulse.
  always_comb begin
    state_next    = state;
    shreg_next    = shreg;
    byte_cnt_next = byte_cnt;
    tx_start_next = 1'b0;
    tx_data_next  = tx_data;
    pop           = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop           = 1'b1;
          shreg_next    = mem[rd_ptr];
          byte_cnt_next = 2'd0;
          state_next    = SEND;
        end
      end
      SEND: begin
        if (bus.tx_ready) begin
          tx_start_next = 1'b1;
          tx_data_next  = shreg[31:24];
          state_next    = ACK;
        end
      end
      ACK: begin
        // tx_ready is still high on the first ACK cycle; wait for the sender
        // to take the byte before moving on.
        if (!bus.tx_ready) begin
          shreg_next    = {shreg[23:0], 8'h00};
          byte_cnt_next = byte_cnt + 2'd1;
          state_next    = (byte_cnt == 2'd3) ? IDLE : SEND;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_word_queue.sv
// Directed bench for uart_tx_word_queue with a behavioural byte sender that
// drops tx_ready the cycle after it samples tx_start and raises it sdly
// cycles later.
module tb_uart_tx_word_queue;

  localparam int DL = 4;

  logic CLK = 1'b0;
  logic reset = 1'b1;

  uart_tx_word_queue_if #(.DEPTH_LOG2(DL)) bus ();

  uart_tx_word_queue #(.DEPTH_LOG2(DL)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Byte sender model and protocol monitor.
  int         sdly      = 10;
  bit         sender_en = 1'b1;
  int         scnt      = 0;
  logic       prev_start = 1'b0;
  int         viol      = 0;
  logic [7:0] rx_q [$];
  logic [7:0] exp_q [$];

  always @(posedge CLK) begin
    if (bus.tx_start === 1'b1 && (bus.tx_ready !== 1'b1 || prev_start === 1'b1))
      viol <= viol + 1;
    prev_start <= bus.tx_start;
    if (scnt > 0) begin
      scnt <= scnt - 1;
      if (scnt == 1) bus.tx_ready <= sender_en;
    end else if (bus.tx_start === 1'b1 && bus.tx_ready === 1'b1) begin
      rx_q.push_back(bus.tx_data);
      bus.tx_ready <= 1'b0;
      scnt <= sdly;
    end else begin
      bus.tx_ready <= sender_en;
    end
  end

  task automatic expect_word(input logic [31:0] w);
    exp_q.push_back(w[31:24]);
    exp_q.push_back(w[23:16]);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
  endtask

  task automatic compare_rx(input string tag);
    int n;
    check({tag, " nbytes"}, rx_q.size(), exp_q.size());
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s byte%0d", tag, i), {24'h0, rx_q[i]}, {24'h0, exp_q[i]});
    rx_q.delete();
    exp_q.delete();
  endtask

  // Called at a negedge; presents one word for exactly one sampling edge.
  task automatic push(input logic [31:0] w);
    bus.wr_data = w;
    bus.wr_en   = 1'b1;
    @(negedge CLK);
    bus.wr_en   = 1'b0;
  endtask

  task automatic push_stall(input logic [31:0] w);
    int g = 0;
    while (bus.full && g < 2000) begin
      @(negedge CLK);
      g++;
    end
    if (bus.full) check("push stall timeout", {31'h0, bus.full}, 32'h0);
    push(w);
  endtask

  task automatic wait_drain(input string tag);
    int g = 0;
    while ((bus.busy || !bus.empty || !bus.tx_ready) && g < 5000) begin
      @(negedge CLK);
      g++;
    end
    check({tag, " drain busy"}, {31'h0, bus.busy}, 32'h0);
    check({tag, " drain count"}, {27'h0, bus.count}, 32'h0);
  endtask

  task automatic stall_sender();
    int g = 0;
    sender_en = 1'b0;
    while (bus.tx_ready && g < 100) begin
      @(negedge CLK);
      g++;
    end
    check("sender stalled", {31'h0, bus.tx_ready}, 32'h0);
  endtask

  task automatic pulse_reset();
    @(negedge CLK);
    reset = 1'b1;
    @(negedge CLK);
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int g;
    logic [31:0] w;
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;

    // Reset held with wr_en asserted must not enqueue anything.
    @(negedge CLK);
    bus.wr_en   = 1'b1;
    bus.wr_data = 32'hDEADBEEF;
    repeat (3) @(negedge CLK);
    check("rst empty",    {31'h0, bus.empty},    32'h1);
    check("rst count",    {27'h0, bus.count},    32'h0);
    check("rst full",     {31'h0, bus.full},     32'h0);
    check("rst tx_start", {31'h0, bus.tx_start}, 32'h0);
    check("rst tx_data",  {24'h0, bus.tx_data},  32'h0);
    check("rst busy",     {31'h0, bus.busy},     32'h0);
    check("rst overflow", {31'h0, bus.overflow}, 32'h0);
    reset      = 1'b0;
    bus.wr_en  = 1'b0;
    @(negedge CLK);
    check("post rst count", {27'h0, bus.count}, 32'h0);
    check("post rst busy",  {31'h0, bus.busy},  32'h0);

    // Single word: two-edge latency to tx_start, MSB first.
    bus.wr_data = 32'h12345678;
    bus.wr_en   = 1'b1;
    @(posedge CLK);
    #1;
    check("single count", {27'h0, bus.count}, 32'h1);
    check("single empty", {31'h0, bus.empty}, 32'h0);
    @(negedge CLK);
    bus.wr_en = 1'b0;
    lat = 0;
    do begin
      @(posedge CLK);
      #1;
      lat++;
    end while (!bus.tx_start && lat < 20);
    check("single latency", lat, 2);
    check("single first byte", {24'h0, bus.tx_data}, 32'h12);
    @(posedge CLK);
    #1;
    check("single pulse width", {31'h0, bus.tx_start}, 32'h0);
    expect_word(32'h12345678);
    wait_drain("single");
    compare_rx("single");

    // Fill with sender stalled. Word 0 is popped into the shift register, so
    // 17 writes fill the 16 slots and the 18th write is dropped.
    stall_sender();
    for (int i = 0; i < 17; i++) push(i);
    check("fill count",    {27'h0, bus.count},    32'd16);
    check("fill full",     {31'h0, bus.full},     32'h1);
    check("fill overflow", {31'h0, bus.overflow}, 32'h0);
    check("fill busy",     {31'h0, bus.busy},     32'h1);
    push(32'd17);
    check("ovf flag",  {31'h0, bus.overflow}, 32'h1);
    check("ovf count", {27'h0, bus.count},    32'd16);
    sender_en = 1'b1;
    for (int i = 0; i < 17; i++) expect_word(i);
    wait_drain("fill");
    compare_rx("fill");
    check("ovf sticky", {31'h0, bus.overflow}, 32'h1);
    pulse_reset();
    check("ovf cleared", {31'h0, bus.overflow}, 32'h0);

    // Full queue with a write landing in the same cycle as the pop.
    stall_sender();
    for (int i = 0; i < 17; i++) push(32'hA000_0000 + i);
    check("pp full", {31'h0, bus.full}, 32'h1);
    sender_en = 1'b1;
    g = 0;
    while (bus.busy && g < 500) begin
      @(negedge CLK);
      g++;
    end
    check("pp idle reached", {31'h0, bus.busy}, 32'h0);
    bus.wr_data = 32'hC0FFEE11;
    bus.wr_en   = 1'b1;
    @(posedge CLK);
    #1;
    check("pp count",    {27'h0, bus.count},    32'd16);
    check("pp overflow", {31'h0, bus.overflow}, 32'h0);
    check("pp busy",     {31'h0, bus.busy},     32'h1);
    @(negedge CLK);
    bus.wr_en = 1'b0;
    for (int i = 0; i < 17; i++) expect_word(32'hA000_0000 + i);
    expect_word(32'hC0FFEE11);
    wait_drain("pp");
    compare_rx("pp");
    check("pp overflow end", {31'h0, bus.overflow}, 32'h0);

    // Pointer wrap: 40 words with irregular gaps, stalling on full.
    sdly = 3;
    for (int i = 0; i < 40; i++) begin
      w = {i[7:0], ~i[7:0], i[7:0] ^ 8'h5A, 8'h30 + i[7:0]};
      push_stall(w);
      expect_word(w);
      repeat (i % 3) @(negedge CLK);
    end
    wait_drain("wrap");
    compare_rx("wrap");
    check("wrap overflow", {31'h0, bus.overflow}, 32'h0);

    // Reset after the second byte of the first word, three words queued.
    sdly = 10;
    push(32'hAABBCCDD);
    push(32'h11111111);
    push(32'h22222222);
    push(32'h33333333);
    g = 0;
    while (rx_q.size() < 2 && g < 200) begin
      @(negedge CLK);
      g++;
    end
    reset = 1'b1;
    @(posedge CLK);
    #1;
    check("mid tx_start", {31'h0, bus.tx_start}, 32'h0);
    check("mid count",    {27'h0, bus.count},    32'h0);
    check("mid busy",     {31'h0, bus.busy},     32'h0);
    check("mid empty",    {31'h0, bus.empty},    32'h1);
    @(negedge CLK);
    reset = 1'b0;
    repeat (40) @(negedge CLK);
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'hBB);
    compare_rx("mid");
    push(32'h01020304);
    expect_word(32'h01020304);
    wait_drain("after rst");
    compare_rx("after rst");

    check("protocol violations", viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
